// File: rtl/md_iter_unit_pkg.sv
// ---------------------------------------------------------------------------
// md_iter_unit_pkg
//   Shared definitions for the iterative multiply/divide unit:
//   operation codes, FSM state encoding and a small op-decode helper.
// ---------------------------------------------------------------------------
package md_iter_unit_pkg;

    localparam logic [1:0] MD_OP_MUL = 2'b11;
    localparam logic [1:0] MD_OP_DIV = 2'b01;

    typedef enum logic [1:0] {
        MD_IDLE    = 2'd0,
        MD_BUSY    = 2'd1,
        MD_DIVZERO = 2'd2,
        MD_DONE    = 2'd3
    } md_state_e;

    // Only MUL and DIV codes start an operation; anything else is a no-op.
    function automatic logic md_op_valid(input logic [1:0] op);
        return (op == MD_OP_MUL) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/md_iter_unit_sign_fix.sv
// ---------------------------------------------------------------------------
// md_sign_fix
//   Combinational sign correction of the unsigned iterative result.
//   Ports:
//     is_div_i  in   1        1 = raw_i is {remainder, quotient}, 0 = product
//     neg_lo_i  in   1        negate product (mul) or quotient (div)
//     neg_hi_i  in   1        negate remainder (div only)
//     raw_i     in   2*WIDTH  unsigned magnitude result
//     fixed_o   out  2*WIDTH  corrected {HI, LO}
// ---------------------------------------------------------------------------
module md_sign_fix
    import md_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 is_div_i,
    input  logic                 neg_lo_i,
    input  logic                 neg_hi_i,
    input  logic [2*WIDTH-1:0]   raw_i,
    output logic [2*WIDTH-1:0]   fixed_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives fixed_o; no latch.
        fixed_o = raw_i;
        if (is_div_i) begin
            if (neg_lo_i) fixed_o[WIDTH-1:0]       = -raw_i[WIDTH-1:0];
            if (neg_hi_i) fixed_o[2*WIDTH-1:WIDTH] = -raw_i[2*WIDTH-1:WIDTH];
        end else if (neg_lo_i) begin
            fixed_o = -raw_i;
        end
    end

endmodule

// File: rtl/md_iter_unit.sv
// ---------------------------------------------------------------------------
// md_iter_unit
//   Iterative 32-bit multiply/divide unit for the EX stage (MULT, MULTU,
//   DIV, DIVU). Shift-add multiplier and restoring divider, one bit per
//   cycle, one operation in flight. Signed operands are reduced to
//   magnitudes on accept; md_sign_fix restores the signs at completion.
//   Ports:
//     clk          in   1        clock
//     rst          in   1        synchronous active-high reset
//     start_i      in   1        request level (sampled only in IDLE)
//     annul_i      in   1        abort in-flight op / block accept in IDLE
//     op_sel_i     in   2        2'b11 mul, 2'b01 div, others ignored
//     md_signed_i  in   1        signed operands
//     opdata1_i    in   WIDTH    multiplicand / dividend
//     opdata2_i    in   WIDTH    multiplier / divisor
//     result_o     out  2*WIDTH  product or {remainder, quotient}
//     ready_o      out  1        one-cycle completion pulse
//     busy_o       out  1        operation in flight (BUSY or DIVZERO)
// ---------------------------------------------------------------------------
module md_iter_unit
    import md_iter_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [1:0]           op_sel_i,
    input  logic                 md_signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    md_state_e            state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;
    logic                 neg_hi_q, neg_hi_d;
    // acc: mul accumulator, or div {rem, quo}; for div-by-zero it holds the
    // final result directly.
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;   // multiplicand, shifts left
    logic [WIDTH-1:0]     opb_q,    opb_d;     // multiplier (shifts right) or divisor
    logic [2*WIDTH-1:0]   result_q, result_d;

    // Operand decode on accept.
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign a_neg = md_signed_i & opdata1_i[WIDTH-1];
    assign b_neg = md_signed_i & opdata2_i[WIDTH-1];
    assign a_mag = a_neg ? -opdata1_i : opdata1_i;
    assign b_mag = b_neg ? -opdata2_i : opdata2_i;

    // One iteration of each datapath.
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   iter_next;
    logic [2*WIDTH-1:0]   fixed;

    assign mul_next = opb_q[0] ? (acc_q + mcand_q) : acc_q;

    // Trial subtract on the shifted upper half, keeping the bit shifted out
    // of the remainder so a remainder >= 2^(WIDTH-1) is not truncated.
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    assign div_next  = div_trial[WIDTH]
                     ? {acc_q[2*WIDTH-2:0], 1'b0}
                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign iter_next = is_div_q ? div_next : mul_next;

    md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .is_div_i (is_div_q),
        .neg_lo_i (neg_lo_q),
        .neg_hi_i (neg_hi_q),
        .raw_i    (iter_next),
        .fixed_o  (fixed)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        result_d = result_q;

        unique case (state_q)
            MD_IDLE: begin
                if (start_i && !annul_i && md_op_valid(op_sel_i)) begin
                    is_div_d = (op_sel_i == MD_OP_DIV);
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    cnt_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    opb_d    = b_mag;
                    if (op_sel_i == MD_OP_DIV) begin
                        if (opdata2_i == '0) begin
                            acc_d   = {opdata1_i, {WIDTH{1'b1}}};
                            state_d = MD_DIVZERO;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            state_d = MD_BUSY;
                        end
                    end else begin
                        acc_d   = '0;
                        state_d = MD_BUSY;
                    end
                end
            end

            MD_BUSY: begin
                if (annul_i) begin
                    state_d = MD_IDLE;
                end else begin
                    acc_d = iter_next;
                    if (!is_div_q) begin
                        mcand_d = mcand_q << 1;
                        opb_d   = opb_q >> 1;
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        result_d = fixed;
                        state_d  = MD_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            MD_DIVZERO: begin
                if (annul_i) begin
                    state_d = MD_IDLE;
                end else begin
                    result_d = acc_q;
                    state_d  = MD_DONE;
                end
            end

            MD_DONE: begin
                state_d = MD_IDLE;
            end

            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every register is reset, including the datapath; there is no
            // memory array here and reset values keep result_o deterministic.
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = (state_q == MD_DONE);
    assign busy_o   = (state_q == MD_BUSY) || (state_q == MD_DIVZERO);

endmodule

// File: tb/tb_md_iter_unit.sv
module tb_md_iter_unit;

    localparam logic [1:0] OP_MUL = 2'b11;
    localparam logic [1:0] OP_DIV = 2'b01;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic [1:0]  op_sel_i;
    logic        md_signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_ready = 0;
    logic prev_ready = 1'b0;
    logic [63:0] exp_q[$];

    md_iter_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .op_sel_i    (op_sel_i),
        .md_signed_i (md_signed_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every ready_o pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_ready = 1'b0;
        end else begin
            if (ready_o) begin
                n_ready++;
                if (prev_ready) check("ready_width", 64'd2, 64'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    check("result", result_o, exp_q.pop_front());
                end
            end
            prev_ready = ready_o;
        end
    end

    // Counts edges after the accept edge until ready_o is seen at a negedge.
    task automatic wait_ready(output int lat);
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = n;
                break;
            end
            @(posedge clk);
        end
        if (lat < 0) check("ready_timeout", 64'd0, 64'd1);
    endtask

    // Called #1 after a posedge with the unit idle.
    task automatic issue(input string name, input logic [1:0] op, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int exp_lat);
        int lat;
        exp_q.push_back(exp);
        op_sel_i = op; md_signed_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        opdata1_i = 32'hDEAD_BEEF;   // latched copies must be used
        opdata2_i = 32'h0000_0000;
        wait_ready(lat);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int r0;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_sel_i = 2'b00;
        md_signed_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result_o, 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Invalid op code ignores start_i; annul_i in IDLE blocks accept.
        op_sel_i = 2'b10; start_i = 1'b1; opdata1_i = 32'd1; opdata2_i = 32'd1;
        repeat (2) @(posedge clk); #1;
        check("invalid_op_busy", 64'(busy_o), 64'd0);
        op_sel_i = OP_MUL; annul_i = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("annul_idle_busy", 64'(busy_o), 64'd0);
        start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;

        issue("multu_max", OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
        issue("mult_m3x5", OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 32);
        issue("mult_min2", OP_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 32);
        issue("div_m7_2",  OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 32);
        issue("div_7_m2",  OP_DIV, 1'b1, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 32);
        issue("divu_100_7",OP_DIV, 1'b0, 32'd100,       32'd7,         64'h0000_0002_0000_000E, 32);
        issue("div_min_m1",OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 32);
        issue("divu_big",  OP_DIV, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 64'h7FFF_FFFE_0000_0001, 32);
        issue("divu_5_0",  OP_DIV, 1'b0, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1);

        // Annul 10 cycles into a MULT: no ready, result unchanged.
        op_sel_i = OP_MUL; md_signed_i = 1'b1; opdata1_i = 32'd11; opdata2_i = 32'd13;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk); #1;
        check("annul_busy_before", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        check("annul_busy_after", 64'(busy_o), 64'd0);
        check("annul_result_kept", result_o, 64'h0000_0005_FFFF_FFFF);
        repeat (40) @(posedge clk); #1;
        issue("divu_9_3",  OP_DIV, 1'b0, 32'd9, 32'd3, 64'h0000_0000_0000_0003, 32);

        // start_i held through DONE: re-accept only in the following IDLE cycle.
        r0 = n_ready;
        exp_q.push_back(64'd42);
        op_sel_i = OP_MUL; md_signed_i = 1'b0; opdata1_i = 32'd7; opdata2_i = 32'd6;
        start_i = 1'b1;
        @(posedge clk); #1;
        wait_ready(lat);
        check("b2b_first_latency", 64'(lat), 64'd32);
        opdata1_i = 32'd2; opdata2_i = 32'd3;
        exp_q.push_back(64'd6);
        @(posedge clk); #1;
        check("b2b_idle_busy", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("b2b_second_busy", 64'(busy_o), 64'd1);
        wait_ready(lat);
        check("b2b_second_latency", 64'(lat), 64'd32);
        repeat (5) @(posedge clk); #1;
        check("b2b_pulse_count", 64'(n_ready - r0), 64'd2);

        // Reset mid-BUSY.
        op_sel_i = OP_MUL; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'hFFFF_FFFF;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk); #1;

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
